prach_chn_extract: RTL and testbench
====================================

Name: prach_chn_extract

Overview:
Receive-side consumer of the antenna-lane TDM bus that the PRACH mixer produces. The bus carries 3 lanes of I/Q, a beat valid, a channel tag and a frame sync. This block tracks the frame/channel sequence, extracts the samples of one selected channel across all 3 lanes, and buffers them in a FIFO. It presents them on a valid/ready stream toward downstream per-channel processing (decimation/FFT). The upstream bus has no backpressure; overflow is detected and reported.

Parameters:
N_CHN, 8, channels per TDM frame (chn tags 0..N_CHN-1)
DEPTH, 16, FIFO depth in entries; power of 2, >= 4

Ports:
clk  in  1  clock
rst_n  in  1  reset: synchronous, active-low
din_dr  in  16 x [3]  lane real samples
din_di  in  16 x [3]  lane imag samples
din_dv  in  1  beat valid
din_chn  in  8  channel tag of beat
sync_in  in  1  frame start; meaningful only when din_dv=1
ctrl_en  in  1  capture enable
ctrl_chn  in  8  channel to extract
stat_clr  in  1  clear sticky status
dout_dr  out  16 x [3]  extracted real samples
dout_di  out  16 x [3]  extracted imag samples
dout_valid  out  1  output valid
dout_ready  in  1  downstream ready
dout_sof  out  1  first extracted sample of a frame
stat_overflow  out  1  sticky: sample dropped, FIFO full
stat_seq_err  out  1  sticky: bad channel sequence
stat_frame_cnt  out  16  accepted frames, wraps 0xFFFF->0

Behaviour:
- Reset (rst_n=0 at clk edge): FSM=UNSYNC; FIFO empty; dout_valid=0; dout_dr/di=0; dout_sof=0; all stats 0; latched channel=0; sof_pend=0.
- Beats are only examined when din_dv=1. Cycles with din_dv=0 are ignored entirely, including any sync_in on them.
- FSM UNSYNC:
  - beat with sync_in=1 and din_chn=0 -> SYNCED; beat accepted; exp_chn=1 mod N_CHN.
  - sync_in=1 with din_chn!=0 -> set stat_seq_err, stay UNSYNC.
  - any other beat is dropped silently.
- FSM SYNCED:
  - beat with din_chn==exp_chn and sync_in=0 -> accepted; exp_chn increments mod N_CHN.
  - sync_in=1 with din_chn=0 -> accepted as a new frame start, whatever exp_chn is. This is a resync, not an error.
  - any other beat -> set stat_seq_err, go UNSYNC, drop the beat.
- On each accepted sync beat:
  - latch ctrl_chn (channel switches are frame-aligned);
  - set sof_pend;
  - increment stat_frame_cnt.
- Capture: an accepted beat with ctrl_en=1 and din_chn == latched channel writes {dr[0..2], di[0..2], sof_pend} to the FIFO, then clears sof_pend.
  - The sync beat itself uses the newly latched channel.
  - A latched channel >= N_CHN never captures.
  - ctrl_en is not latched; deasserting it stops captures the next beat, and the FIFO drains normally.
- FIFO write when full: allowed only if a pop occurs in the same cycle. Otherwise the sample is dropped and stat_overflow is set. A dropped sample that carried sof leaves sof_pend set, so the next capture carries sof.
- Output: first-word-fall-through with a registered head.
  - A write at edge T makes dout_valid=1 after edge T+1 if the FIFO was empty (1-cycle write-to-valid latency).
  - Pop on dout_valid & dout_ready. Throughput is 1 entry/cycle.
  - dout_* hold stable while dout_valid=1 and dout_ready=0.
  - dout_dr/di/sof hold their last value when dout_valid=0.
- stat_clr clears both sticky flags (not stat_frame_cnt). If a set condition occurs in the same cycle, set wins.
- Samples pass through unmodified: no arithmetic and no width change.

Decomposition:
- prach_pkg: NumLane=3, sample typedef (16-bit signed re/im), packed lane-vector typedef, FIFO entry struct {re[3], im[3], sof}.
- Sub-module prach_sfifo: single-clock FWFT FIFO parameterised on width and depth, with push/pop/full/empty/count outputs. This block contains the FSM, capture logic, stats and FIFO instance.

Test Plan:
- Nominal: sync with chn 0, then 0..7 cyclic for 4 frames, ctrl_chn=3, ready=1. Expect 4 outputs carrying the chn-3 data values, sof=1 on each, stat_frame_cnt=4, no errors.
- Sequence error: in frame 2 send chn 5 where 4 is expected. Expect stat_seq_err=1 and no captures until the next sync. Captures resume with sof=1. stat_clr then clears the flag.
- Overflow: DEPTH=16, ready=0, 20 frames with chn 2 selected. Expect 16 entries, stat_overflow=1, and the first entry popped is from frame 1.
- Full with simultaneous push and pop: FIFO full, ready=1 on the capture cycle. Expect the write to be accepted and stat_overflow=0.
- Channel switch: change ctrl_chn 1->6 mid-frame. Expect chn-1 capture to continue until the next sync, then chn 6 starting with sof=1. ctrl_chn=9 gives no captures.
- Reset mid-operation: rst_n=0 for 1 cycle with 5 FIFO entries buffered. Expect dout_valid=0 next cycle, stats 0, and UNSYNC (beats ignored until sync with chn 0).

Source files
------------

// File: rtl/prach_pkg.sv
// Shared types for the PRACH receive-side lane bus.
//   NumLane      : antenna lanes carried per TDM beat
//   sample_t     : one signed 16-bit I or Q sample
//   lane_vec_t   : one sample per lane, packed
//   fifo_entry_t : buffered capture {re lanes, im lanes, start-of-frame}
//   sync_state_t : frame/channel tracker states
//   chn_next     : channel tag increment modulo the frame length
package prach_pkg;

    localparam int unsigned NumLane = 3;
    localparam int unsigned SampleW = 16;
    localparam int unsigned ChnW    = 8;

    typedef logic signed [SampleW-1:0] sample_t;
    typedef sample_t [NumLane-1:0]      lane_vec_t;

    typedef struct packed {
        lane_vec_t re;
        lane_vec_t im;
        logic      sof;
    } fifo_entry_t;

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_SYNCED = 1'b1
    } sync_state_t;

    function automatic logic [ChnW-1:0] chn_next(input logic [ChnW-1:0] chn,
                                                 input int unsigned     n_chn);
        if (32'(chn) + 32'd1 >= n_chn) begin
            return '0;
        end
        return chn + ChnW'(1);
    endfunction

endpackage

// File: rtl/prach_sfifo.sv
// Single-clock first-word-fall-through FIFO with a registered head.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : write push_data (ignored when full unless pop in same cycle)
//   push_data  : write data
//   pop        : consume the presented head (ignored when empty)
//   pop_data   : head entry; holds its last value while empty
//   full       : DEPTH entries held (storage plus head)
//   empty      : no head presented
//   count      : entries held, including the head
module prach_sfifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      mem_cnt;
    logic             head_valid;
    logic             pop_do;
    logic             push_do;
    logic             head_load;

    assign count = mem_cnt + {{AW{1'b0}}, head_valid};
    assign empty = !head_valid;

    // A write lands in storage first and reaches the head on a later edge,
    // giving the one-cycle write-to-valid latency; the head refills from
    // storage on the same edge it is popped, so throughput stays 1/cycle.
    always_comb begin
        pop_do    = pop && head_valid;
        full      = (count == (AW+1)'(DEPTH));
        push_do   = push && (!full || pop_do);
        head_load = (mem_cnt != '0) && (!head_valid || pop_do);
    end

    always_ff @(posedge clk) begin
        if (push_do) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            head_valid <= 1'b0;
            pop_data   <= '0;
        end else begin
            if (push_do) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push_do, head_load})
                2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
            if (head_load) begin
                pop_data   <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + AW'(1);
                head_valid <= 1'b1;
            end else if (pop_do) begin
                head_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prach_chn_extract.sv
// Extracts one channel of the PRACH antenna-lane TDM bus into a stream.
//   clk, rst_n      : clock, synchronous active-low reset
//   din_dr/din_di   : lane I/Q samples of the current beat
//   din_dv          : beat valid; nothing else is looked at when low
//   din_chn         : channel tag of the beat
//   sync_in         : frame start marker (with din_dv)
//   ctrl_en         : capture enable, applied per beat
//   ctrl_chn        : channel to extract, latched on each frame start
//   stat_clr        : clears the sticky flags
//   dout_dr/dout_di : extracted lane samples (FWFT head)
//   dout_valid      : head present
//   dout_ready      : downstream accepts the head
//   dout_sof        : head is the first capture of a frame
//   stat_overflow   : sticky, capture dropped on a full FIFO
//   stat_seq_err    : sticky, channel sequence broken
//   stat_frame_cnt  : accepted frame starts, wrapping
module prach_chn_extract
    import prach_pkg::*;
#(
    parameter int unsigned N_CHN = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NumLane-1:0][SampleW-1:0]  din_dr,
    input  logic [NumLane-1:0][SampleW-1:0]  din_di,
    input  logic                             din_dv,
    input  logic [ChnW-1:0]                  din_chn,
    input  logic                             sync_in,
    input  logic                             ctrl_en,
    input  logic [ChnW-1:0]                  ctrl_chn,
    input  logic                             stat_clr,
    output logic [NumLane-1:0][SampleW-1:0]  dout_dr,
    output logic [NumLane-1:0][SampleW-1:0]  dout_di,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic                             dout_sof,
    output logic                             stat_overflow,
    output logic                             stat_seq_err,
    output logic [15:0]                      stat_frame_cnt
);

    sync_state_t      state_q;
    sync_state_t      state_d;
    logic [ChnW-1:0]  exp_chn_q;
    logic [ChnW-1:0]  lat_chn_q;
    logic             sof_pend_q;
    logic [15:0]      frame_cnt_q;
    logic             ovf_q;
    logic             seq_q;

    logic             accept;
    logic             sync_acc;
    logic             seq_err_set;
    logic [ChnW-1:0]  cap_chn;
    logic             cap_hit;
    logic             pop;
    logic             push_ok;
    logic             ovf_set;
    fifo_entry_t      wr_entry;
    fifo_entry_t      head;
    logic             fifo_full;
    logic             fifo_empty;
    // Occupancy is not needed here; fullness comes from fifo_full.
    logic [$clog2(DEPTH):0] fifo_cnt_unused;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_UNSYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        sync_acc    = 1'b0;
        seq_err_set = 1'b0;
        if (din_dv) begin
            case (state_q)
                ST_UNSYNC: begin
                    if (sync_in && (din_chn == '0)) begin
                        state_d  = ST_SYNCED;
                        accept   = 1'b1;
                        sync_acc = 1'b1;
                    end else if (sync_in) begin
                        seq_err_set = 1'b1;
                    end
                end
                ST_SYNCED: begin
                    // A chn-0 sync always restarts the frame, even mid-frame.
                    if (sync_in && (din_chn == '0)) begin
                        accept   = 1'b1;
                        sync_acc = 1'b1;
                    end else if (!sync_in && (din_chn == exp_chn_q)) begin
                        accept = 1'b1;
                    end else begin
                        seq_err_set = 1'b1;
                        state_d     = ST_UNSYNC;
                    end
                end
                default: state_d = ST_UNSYNC;
            endcase
        end
    end

    // The sync beat captures against the channel being latched on that beat.
    always_comb begin
        cap_chn      = sync_acc ? ctrl_chn : lat_chn_q;
        cap_hit      = accept && ctrl_en && (din_chn == cap_chn)
                       && (32'(cap_chn) < N_CHN);
        pop          = dout_valid && dout_ready;
        push_ok      = cap_hit && (!fifo_full || pop);
        ovf_set      = cap_hit && !push_ok;
        wr_entry.re  = din_dr;
        wr_entry.im  = din_di;
        wr_entry.sof = sync_acc || sof_pend_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_chn_q   <= '0;
            lat_chn_q   <= '0;
            sof_pend_q  <= 1'b0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            seq_q       <= 1'b0;
        end else begin
            if (sync_acc) begin
                exp_chn_q   <= chn_next('0, N_CHN);
                lat_chn_q   <= ctrl_chn;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end else if (accept) begin
                exp_chn_q <= chn_next(exp_chn_q, N_CHN);
            end
            // A dropped capture keeps sof pending for the next one.
            if (push_ok) begin
                sof_pend_q <= 1'b0;
            end else if (sync_acc) begin
                sof_pend_q <= 1'b1;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (stat_clr) begin
                ovf_q <= 1'b0;
            end
            if (seq_err_set) begin
                seq_q <= 1'b1;
            end else if (stat_clr) begin
                seq_q <= 1'b0;
            end
        end
    end

    prach_sfifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap_hit),
        .push_data (wr_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt_unused)
    );

    assign dout_valid     = !fifo_empty;
    assign dout_dr        = head.re;
    assign dout_di        = head.im;
    assign dout_sof       = head.sof;
    assign stat_overflow  = ovf_q;
    assign stat_seq_err   = seq_q;
    assign stat_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_prach_chn_extract.sv
// Randomised scoreboard bench for prach_chn_extract.
module tb_prach_chn_extract;

    localparam int N_CHN = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0][15:0] din_dr = '0;
    logic [2:0][15:0] din_di = '0;
    logic             din_dv = 1'b0;
    logic [7:0]       din_chn = '0;
    logic             sync_in = 1'b0;
    logic             ctrl_en = 1'b0;
    logic [7:0]       ctrl_chn = '0;
    logic             stat_clr = 1'b0;
    logic [2:0][15:0] dout_dr;
    logic [2:0][15:0] dout_di;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             dout_sof;
    logic             stat_overflow;
    logic             stat_seq_err;
    logic [15:0]      stat_frame_cnt;

    typedef struct packed {
        logic [47:0] re;
        logic [47:0] im;
        logic        sof;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    bit   started = 0;
    bit   rnd_mode = 0;

    always #5 clk = ~clk;

    prach_chn_extract #(
        .N_CHN (N_CHN),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .din_dr         (din_dr),
        .din_di         (din_di),
        .din_dv         (din_dv),
        .din_chn        (din_chn),
        .sync_in        (sync_in),
        .ctrl_en        (ctrl_en),
        .ctrl_chn       (ctrl_chn),
        .stat_clr       (stat_clr),
        .dout_dr        (dout_dr),
        .dout_di        (dout_di),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .dout_sof       (dout_sof),
        .stat_overflow  (stat_overflow),
        .stat_seq_err   (stat_seq_err),
        .stat_frame_cnt (stat_frame_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: sync tracker, occupancy count and presentation flag.
    int m_exp = 0, m_lat = 0, m_fcnt = 0, m_cnt = 0;
    bit m_synced = 0, m_sofp = 0, m_ovf = 0, m_seq = 0, m_pres = 0;

    always @(posedge clk) begin : model
        bit   pop, acc, sacc, serr, cap, pushed, ovf_set;
        int   cc;
        exp_t e;
        if (!rst_n) begin
            m_synced = 0; m_exp = 0; m_lat = 0; m_fcnt = 0; m_cnt = 0;
            m_sofp = 0; m_ovf = 0; m_seq = 0; m_pres = 0;
            sb.delete();
        end else begin
            pop = m_pres && dout_ready;
            acc = 0; sacc = 0; serr = 0; pushed = 0; ovf_set = 0;
            if (din_dv) begin
                if (sync_in && din_chn == 0) begin
                    acc = 1; sacc = 1;
                end else if (m_synced && !sync_in && int'(din_chn) == m_exp) begin
                    acc = 1;
                end else if (m_synced || sync_in) begin
                    serr = 1;
                end
            end
            cc  = sacc ? int'(ctrl_chn) : m_lat;
            cap = acc && ctrl_en && int'(din_chn) == cc && cc < N_CHN;
            if (sacc) begin
                m_synced = 1; m_exp = 1 % N_CHN; m_lat = int'(ctrl_chn);
                m_fcnt = (m_fcnt + 1) % 65536; m_sofp = 1;
            end else if (acc) begin
                m_exp = (m_exp + 1) % N_CHN;
            end
            if (serr) m_synced = 0;
            if (cap) begin
                if (m_cnt < DEPTH || pop) begin
                    e.re = din_dr; e.im = din_di; e.sof = m_sofp;
                    sb.push_back(e);
                    m_sofp = 0; pushed = 1;
                end else begin
                    ovf_set = 1;
                end
            end
            m_ovf = ovf_set ? 1'b1 : (stat_clr ? 1'b0 : m_ovf);
            m_seq = serr ? 1'b1 : (stat_clr ? 1'b0 : m_seq);
            if (pop) begin m_cnt--; m_pres = 0; end
            if (pushed) m_cnt++;
            if (!m_pres && (m_cnt - int'(pushed)) > 0) m_pres = 1;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t a;
        if (started && rst_n) begin
            chk("valid", dout_valid, m_pres);
            chk("overflow", stat_overflow, m_ovf);
            chk("seq_err", stat_seq_err, m_seq);
            chk("frame_cnt", stat_frame_cnt, m_fcnt[15:0]);
            if (dout_valid === 1'b1) begin
                a.re = dout_dr; a.im = dout_di; a.sof = dout_sof;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL data actual=%h required=none (no entry expected)", a);
                end else begin
                    chk("data", a, sb[0]);
                    if (dout_ready) begin
                        void'(sb.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        stat_clr = rnd_mode && ($urandom % 24 == 0);
        if (rnd_mode) dout_ready = ($urandom % 2) == 1;
    endtask

    task automatic beat(input int chn, input bit sy);
        din_dv = 1'b1; din_chn = 8'(chn); sync_in = sy;
        for (int l = 0; l < 3; l++) begin
            din_dr[l] = 16'($urandom); din_di[l] = 16'($urandom);
        end
        if (rnd_mode) ctrl_en = ($urandom % 10) != 0;
        tick();
        din_dv = 1'b0; sync_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din_dv = 1'b0; sync_in = 1'($urandom); din_chn = 8'($urandom % N_CHN);
            tick();
        end
        sync_in = 1'b0;
    endtask

    // bad_at: index sent with the wrong tag (-2 = random faults)
    // sw_at : index before which ctrl_chn becomes sw_val
    // rdy_at: index on whose beat dout_ready pulses high
    task automatic frame(input int bad_at, input int sw_at, input int sw_val,
                         input int rdy_at, input int gap_max);
        for (int c = 0; c < N_CHN; c++) begin
            int ch;
            bit sy;
            ch = c; sy = (c == 0);
            if (c == sw_at) ctrl_chn = 8'(sw_val);
            if (c == rdy_at) dout_ready = 1'b1;
            if (c == bad_at) ch = (c + 1) % N_CHN;
            if (bad_at == -2 && $urandom % 24 == 0) begin
                if ($urandom % 2 == 0) sy = ~sy;
                else ch = $urandom % N_CHN;
            end
            beat(ch, sy);
            if (c == rdy_at) dout_ready = 1'b0;
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
        end
    endtask

    task automatic drain();
        int n;
        rnd_mode = 0; dout_ready = 1'b1; n = 0;
        while ((dout_valid === 1'b1 || sb.size() != 0) && n < 200) begin
            idle(1); n++;
        end
        idle(2);
        chk("drain_bound", n < 200, 1'b1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int p0;
        repeat (3) tick();
        rst_n = 1'b1; started = 1;
        chk("reset_valid", dout_valid, 1'b0);
        chk("reset_frames", stat_frame_cnt, 16'd0);
        chk("reset_dout", {dout_dr, dout_di, dout_sof}, '0);

        // Nominal: chn 3 over four frames
        ctrl_en = 1'b1; ctrl_chn = 8'd3; dout_ready = 1'b1;
        repeat (4) frame(-1, -1, 0, -1, 0);
        idle(4);
        chk("nominal_pops", pops, 4);
        chk("nominal_frames", stat_frame_cnt, 16'd4);
        chk("nominal_seq", stat_seq_err, 1'b0);

        // Sequence error, recovery, clear, set-wins-over-clear
        frame(4, -1, 0, -1, 0);
        chk("seq_set", stat_seq_err, 1'b1);
        frame(-1, -1, 0, -1, 1);
        stat_clr = 1'b1; idle(1);
        chk("seq_clr", stat_seq_err, 1'b0);
        beat(3, 1);
        stat_clr = 1'b1; idle(1);
        stat_clr = 1'b1; beat(5, 1);
        chk("seq_set_wins", stat_seq_err, 1'b1);
        drain();

        // Overflow with ready low, then full with push+pop
        ctrl_chn = 8'd2; dout_ready = 1'b0;
        repeat (20) frame(-1, -1, 0, -1, 0);
        chk("ovf_set", stat_overflow, 1'b1);
        stat_clr = 1'b1; idle(1);
        chk("ovf_clr", stat_overflow, 1'b0);
        frame(-1, -1, 0, 2, 0);
        chk("full_pushpop", stat_overflow, 1'b0);
        drain();

        // Channel switch mid-frame, then an out-of-range channel
        p0 = pops; ctrl_chn = 8'd1;
        frame(-1, -1, 0, -1, 0);
        frame(-1, 1, 6, -1, 0);
        frame(-1, -1, 0, -1, 0);
        drain();
        chk("switch_pops", pops - p0, 3);
        p0 = pops; ctrl_chn = 8'd9;
        repeat (2) frame(-1, -1, 0, -1, 0);
        drain();
        chk("bad_chn_pops", pops - p0, 0);

        // Randomised traffic
        rnd_mode = 1;
        for (int f = 0; f < 40; f++) begin
            frame(-2, $urandom_range(N_CHN - 1, 0), $urandom_range(9, 0), -1, 3);
        end
        ctrl_en = 1'b1;
        drain();

        // Reset with entries buffered
        ctrl_chn = 8'd0; dout_ready = 1'b0;
        repeat (5) frame(-1, -1, 0, -1, 0);
        chk("pre_reset_valid", dout_valid, 1'b1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("post_reset_valid", dout_valid, 1'b0);
        chk("post_reset_frames", stat_frame_cnt, 16'd0);
        beat(1, 0); beat(2, 0); beat(3, 0); beat(0, 0);
        chk("unsync_drop_seq", stat_seq_err, 1'b0);
        chk("unsync_drop_valid", dout_valid, 1'b0);
        dout_ready = 1'b1;
        frame(-1, -1, 0, -1, 0);
        drain();
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
